// File: rtl/controle_sequencial.sv
// Sequential control unit: decodes a 3-bit opcode, steers the datapath muxes and
// memory write strobe, handles ALU overflow, halts, and streams a memory dump.
module controle_sequencial #(
  parameter int OP_W   = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              ovf,
  output logic [1:0]        sel_mux1,
  output logic              sel_mux2,
  output logic              sel_mux3,
  output logic              mem_we,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              ended,
  output logic              DUMP,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {StIdle, StExec, StOvf, StHalt, StDmp} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e              state_q, state_d;
  logic [2:0]          opr_q, opr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                illegal_q, illegal_d;

  // Upper opcode bits carry no meaning for this block.
  if (OP_W > 3) begin : g_unused_op
    logic unused_op_hi;
    assign unused_op_hi = ^op[OP_W-1:3];
  end

  // State register with asynchronous abort to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      opr_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opr_q     <= opr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state decision; ovf only matters at the end of an EXEC cycle.
  always_comb begin
    state_d   = state_q;
    opr_d     = opr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          opr_d = op[2:0];
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          unique case (op[2:0])
            3'b100:         state_d = StHalt;
            3'b111: begin
              state_d = StDmp;
              addr_d  = '0;
            end
            3'b101, 3'b110: illegal_d = 1'b1;
            default:        state_d = StExec;
          endcase
        end
      end
      StExec: state_d = ovf ? StOvf : StIdle;
      StOvf:  state_d = StIdle;
      StHalt: state_d = StHalt;
      StDmp: begin
        if (dump_ready) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StIdle;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; handshakes are also masked by rst.
  always_comb begin
    sel_mux1    = 2'd0;
    sel_mux2    = 1'b0;
    sel_mux3    = 1'b0;
    mem_we      = 1'b0;
    op_ready    = (state_q == StIdle) && !rst;
    dump_valid  = (state_q == StDmp) && !rst;
    ended       = (state_q == StHalt);
    DUMP        = (state_q == StDmp);
    illegal     = illegal_q;
    dump_addr   = addr_q;
    instr_count = cnt_q;
    unique case (state_q)
      StExec: begin
        sel_mux1 = {1'b0, opr_q[1]};
        sel_mux2 = opr_q[0];
        mem_we   = 1'b1;
      end
      StOvf: begin
        // Increment the overflow slot: mem[DEPTH-1] + 1.
        sel_mux1 = 2'd2;
        sel_mux2 = 1'b1;
        sel_mux3 = 1'b1;
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_sequencial.sv
// Bench for controle_sequencial: directed scenarios followed by random traffic,
// all checked against a behavioural model of the instruction semantics.
module tb_controle_sequencial;

  localparam int OP_W   = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [OP_W-1:0]   op;
  logic              op_valid, ovf, dump_ready;
  logic              op_ready, sel_mux2, sel_mux3, mem_we, dump_valid, ended, dump_o, illegal;
  logic [1:0]        sel_mux1;
  logic [ADDR_W-1:0] dump_addr;
  logic [CNT_W-1:0]  instr_count;

  // Narrow-counter instance for saturation checks.
  logic              c2_op_ready, c2_sel_mux2, c2_sel_mux3, c2_mem_we, c2_dump_valid;
  logic              c2_ended, c2_dump, c2_illegal;
  logic [1:0]        c2_sel_mux1;
  logic [ADDR_W-1:0] c2_dump_addr;
  logic [1:0]        c2_instr_count;

  always #5 clk = ~clk;

  controle_sequencial #(.OP_W(OP_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .op_ready(op_ready), .ovf(ovf),
    .sel_mux1(sel_mux1), .sel_mux2(sel_mux2), .sel_mux3(sel_mux3), .mem_we(mem_we),
    .dump_addr(dump_addr), .dump_valid(dump_valid), .dump_ready(dump_ready), .ended(ended),
    .DUMP(dump_o), .illegal(illegal), .instr_count(instr_count)
  );

  controle_sequencial #(.OP_W(OP_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .op_ready(c2_op_ready), .ovf(ovf),
    .sel_mux1(c2_sel_mux1), .sel_mux2(c2_sel_mux2), .sel_mux3(c2_sel_mux3),
    .mem_we(c2_mem_we), .dump_addr(c2_dump_addr), .dump_valid(c2_dump_valid),
    .dump_ready(dump_ready), .ended(c2_ended), .DUMP(c2_dump), .illegal(c2_illegal),
    .instr_count(c2_instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the processor is currently doing.
  bit m_halted, m_dumping, m_exec, m_ovf_fix, m_illegal;
  int m_ptr, m_count, m_opr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return !m_halted && !m_dumping && !m_exec && !m_ovf_fix;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_dumping = 0; m_exec = 0; m_ovf_fix = 0; m_illegal = 0;
    m_ptr = 0; m_count = 0; m_opr = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit was_idle = m_idle();
    m_illegal = 0;
    if (was_idle) begin
      if (op_valid) begin
        m_count = m_count + 1;
        m_opr   = int'(op) % 8;
        if (m_opr < 4) m_exec = 1;
        else if (m_opr == 4) m_halted = 1;
        else if (m_opr == 7) begin m_dumping = 1; m_ptr = 0; end
        else m_illegal = 1;
      end
    end else if (m_exec) begin
      m_exec    = 0;
      m_ovf_fix = ovf;
    end else if (m_ovf_fix) begin
      m_ovf_fix = 0;
    end else if (m_dumping && dump_ready) begin
      if (m_ptr == DEPTH - 1) begin m_dumping = 0; m_ptr = 0; end
      else m_ptr = m_ptr + 1;
    end
  endtask

  task automatic compare_all();
    int e_sel1 = m_exec ? (m_opr / 2) % 2 : (m_ovf_fix ? 2 : 0);
    int e_sel2 = m_exec ? m_opr % 2 : (m_ovf_fix ? 1 : 0);
    int e_cnt  = (m_count > 255) ? 255 : m_count;
    int e_cnt2 = (m_count > 3) ? 3 : m_count;
    check_eq("op_ready", op_ready, m_idle());
    check_eq("sel_mux1", sel_mux1, e_sel1);
    check_eq("sel_mux2", sel_mux2, e_sel2);
    check_eq("sel_mux3", sel_mux3, m_ovf_fix);
    check_eq("mem_we", mem_we, m_exec || m_ovf_fix);
    check_eq("dump_valid", dump_valid, m_dumping);
    check_eq("DUMP", dump_o, m_dumping);
    check_eq("dump_addr", dump_addr, m_ptr);
    check_eq("ended", ended, m_halted);
    check_eq("illegal", illegal, m_illegal);
    check_eq("instr_count", instr_count, e_cnt);
    check_eq("instr_count_w2", c2_instr_count, e_cnt2);
  endtask

  // One clock: check outputs mid-cycle, then let the edge happen.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_op_ready", op_ready, 0);
    check_eq("rst_dump_valid", dump_valid, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_DUMP", dump_o, 0);
    check_eq("rst_dump_addr", dump_addr, 0);
    check_eq("rst_ended", ended, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_instr_count", instr_count, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [7:0] code);
    op = code; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    bit dr;
    int bound;
    int halt_cycles;
    rst = 1'b0; op = '0; op_valid = 1'b0; ovf = 1'b0; dump_ready = 1'b0;
    #2;
    do_reset();

    // Simple EXEC without overflow.
    ovf = 1'b0;
    issue(8'h01);
    step();
    step();
    check_eq("count_after_first", instr_count, 1);

    // EXEC with overflow, then the OVF fix-up cycle.
    issue(8'h02);
    ovf = 1'b1;
    step();
    ovf = 1'b0;
    step();
    step();

    // Illegal opcode with junk in the upper bits.
    issue(8'hF5);
    step();
    step();

    // Dump with back-pressure toggling.
    dump_ready = 1'b1;
    issue(8'h07);
    dr = 1'b1;
    bound = 0;
    while (m_dumping && bound < 100) begin
      dump_ready = dr;
      step();
      dr = ~dr;
      bound++;
    end
    check_eq("dump_finished", m_dumping, 0);
    dump_ready = 1'b0;
    step();
    step();

    // Halt: further requests are ignored until reset.
    issue(8'h04);
    for (int i = 0; i < 6; i++) begin
      op = 8'($urandom); op_valid = 1'($urandom);
      step();
    end
    op_valid = 1'b0;
    do_reset();
    step();

    // Narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      issue(8'h00);
      step();
    end

    // Reset in the middle of a dump.
    dump_ready = 1'b1;
    issue(8'h07);
    bound = 0;
    while (m_ptr != 6 && bound < 50) begin
      step();
      bound++;
    end
    check_eq("dump_reached_6", dump_addr, 6);
    do_reset();
    step();

    // Random traffic.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      op         = 8'($urandom);
      op_valid   = ($urandom_range(0, 1) == 1);
      ovf        = 1'($urandom);
      dump_ready = ($urandom_range(0, 3) != 0);
      step();
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
